// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : regfile_wb_arbiter_if
// Brief    : Writeback request bus, register-file write drive and scoreboard
//            reserve/check signals shared between pipeline and arbiter.
// Revision : 1.0
//------------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_reg;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wb_en;
    logic [4:0]           wb_reg;
    logic [31:0]          wb_data;
    logic                 rsv_en;
    logic [4:0]           rsv_reg;
    logic [4:0]           chk_regA;
    logic [4:0]           chk_regB;
    logic                 busyA;
    logic                 busyB;

    // Pipeline / issue side
    modport master (
        output hold, req_valid, req_reg, req_data, rsv_en, rsv_reg, chk_regA, chk_regB,
        input  req_ready, wb_en, wb_reg, wb_data, busyA, busyB
    );

    // Arbiter side
    modport slave (
        input  hold, req_valid, req_reg, req_data, rsv_en, rsv_reg, chk_regA, chk_regB,
        output req_ready, wb_en, wb_reg, wb_data, busyA, busyB
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : regfile_wb_arbiter
// Brief    : Round-robin arbiter for the single register-file write port, with
//            a 32-entry pending-write scoreboard for issue stalls.
// Revision : 1.0
//------------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 3
) (
    input  wire                    clock,
    input  wire                    ctrl_reset,
    regfile_wb_arbiter_if.slave    bus
);

    logic [PTR_W-1:0] r_rr_ptr;
    logic             r_wb_en;
    logic [4:0]       r_wb_reg;
    logic [31:0]      r_wb_data;
    logic [31:0]      r_pending;

    logic [NREQ-1:0]  w_ready;
    logic             w_found;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_next_ptr;
    logic [4:0]       w_sel_reg;
    logic [31:0]      w_sel_data;
    logic [31:0]      w_clr_mask;
    logic [31:0]      w_set_mask;
    logic [31:0]      w_pending_next;

    // Search order starts at the pointer; j is matched against the rotated slot
    // so every select uses a constant index after unrolling.
    always_comb begin
        w_ready = '0;
        w_found = 1'b0;
        w_gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && !bus.hold && bus.req_valid[j] &&
                    (((int'(r_rr_ptr) + i) % NREQ) == j)) begin
                    w_found    = 1'b1;
                    w_ready[j] = 1'b1;
                    w_gidx     = PTR_W'(j);
                end
            end
        end
    end

    always_comb begin
        w_sel_reg  = '0;
        w_sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_ready[j]) begin
                w_sel_reg  = bus.req_reg[5*j +: 5];
                w_sel_data = bus.req_data[32*j +: 32];
            end
        end
    end

    assign w_next_ptr = (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + PTR_W'(1);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_rr_ptr  <= '0;
            r_wb_en   <= 1'b0;
            r_wb_reg  <= '0;
            r_wb_data <= '0;
        end else if (w_found) begin
            r_rr_ptr  <= w_next_ptr;
            // A grant for r0 is consumed but never reaches the register file
            r_wb_en   <= (w_sel_reg != 5'd0);
            r_wb_reg  <= w_sel_reg;
            r_wb_data <= w_sel_data;
        end else begin
            r_wb_en   <= 1'b0;
        end
    end

    // Clear for the landing write, then set for a new reservation so that a
    // same-edge re-reservation keeps the register busy.
    always_comb begin
        w_clr_mask = '0;
        w_set_mask = '0;
        if (r_wb_en) begin
            w_clr_mask[r_wb_reg] = 1'b1;
        end
        if (bus.rsv_en && (bus.rsv_reg != 5'd0)) begin
            w_set_mask[bus.rsv_reg] = 1'b1;
        end
        w_pending_next = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_reg    = r_wb_reg;
    assign bus.wb_data   = r_wb_data;
    assign bus.busyA     = r_pending[bus.chk_regA];
    assign bus.busyB     = r_pending[bus.chk_regB];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_regfile_wb_arbiter
// Brief    : Directed self-checking bench for regfile_wb_arbiter (NREQ=3).
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

    logic clock;
    logic ctrl_reset;
    int   n_checks;
    int   n_errors;

    regfile_wb_arbiter_if #(.NREQ(3)) u_if ();

    regfile_wb_arbiter #(
        .NREQ  (3),
        .PTR_W (3)
    ) u_dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (u_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [4:0] rg, input logic [31:0] dat);
        u_if.req_reg[5*idx +: 5]    = rg;
        u_if.req_data[32*idx +: 32] = dat;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ctrl_reset      = 1'b1;
        u_if.hold       = 1'b0;
        u_if.req_valid  = '0;
        u_if.req_reg    = '0;
        u_if.req_data   = '0;
        u_if.rsv_en     = 1'b0;
        u_if.rsv_reg    = '0;
        u_if.chk_regA   = '0;
        u_if.chk_regB   = '0;
        tick();
        tick();
        check("rst_wb_en",   {31'd0, u_if.wb_en}, 32'd0);
        check("rst_wb_reg",  {27'd0, u_if.wb_reg}, 32'd0);
        check("rst_wb_data", u_if.wb_data, 32'd0);
        ctrl_reset = 1'b0;

        // Single request
        set_req(0, 5'd5, 32'hDEAD_BEEF);
        u_if.req_valid = 3'b001;
        #1;
        check("single_ready", {29'd0, u_if.req_ready}, 32'd1);
        tick();
        u_if.req_valid = 3'b000;
        check("single_wb_en",   {31'd0, u_if.wb_en}, 32'd1);
        check("single_wb_reg",  {27'd0, u_if.wb_reg}, 32'd5);
        check("single_wb_data", u_if.wb_data, 32'hDEAD_BEEF);
        tick();
        check("single_wb_en_off", {31'd0, u_if.wb_en}, 32'd0);

        // Restart the pointer at 0, then all three continuously valid
        ctrl_reset = 1'b1;
        #1;
        ctrl_reset = 1'b0;
        set_req(0, 5'd1, 32'h0000_0100);
        set_req(1, 5'd2, 32'h0000_0101);
        set_req(2, 5'd3, 32'h0000_0102);
        u_if.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check($sformatf("rr_ready_%0d", k), {29'd0, u_if.req_ready}, 32'd1 << (k % 3));
            tick();
            check($sformatf("rr_wb_en_%0d", k),   {31'd0, u_if.wb_en}, 32'd1);
            check($sformatf("rr_wb_reg_%0d", k),  {27'd0, u_if.wb_reg}, 32'((k % 3) + 1));
            check($sformatf("rr_wb_data_%0d", k), u_if.wb_data, 32'h0000_0100 + 32'(k % 3));
        end
        u_if.req_valid = 3'b000;

        // Register 0 drop: grant consumed, pointer moves to 2
        set_req(1, 5'd0, 32'h1111_0000);
        u_if.req_valid = 3'b010;
        #1;
        check("r0_ready", {29'd0, u_if.req_ready}, 32'b010);
        tick();
        check("r0_wb_en", {31'd0, u_if.wb_en}, 32'd0);
        set_req(1, 5'd4, 32'h0000_0444);
        set_req(2, 5'd6, 32'h0000_0666);
        u_if.req_valid = 3'b110;
        #1;
        check("r0_next_ready", {29'd0, u_if.req_ready}, 32'b100);
        tick();
        u_if.req_valid = 3'b010;
        check("r0_next_wb_reg", {27'd0, u_if.wb_reg}, 32'd6);
        check("r0_next_wb_en",  {31'd0, u_if.wb_en}, 32'd1);
        #1;
        check("r0_req1_ready", {29'd0, u_if.req_ready}, 32'b010);
        tick();
        u_if.req_valid = 3'b000;
        check("r0_req1_wb_reg", {27'd0, u_if.wb_reg}, 32'd4);
        tick();

        // Scoreboard: reserve 7, write it back through req2
        u_if.chk_regA = 5'd7;
        u_if.chk_regB = 5'd0;
        u_if.rsv_en   = 1'b1;
        u_if.rsv_reg  = 5'd7;
        #1;
        check("sb_no_bypass", {31'd0, u_if.busyA}, 32'd0);
        tick();
        u_if.rsv_en = 1'b0;
        check("sb_busyA_set", {31'd0, u_if.busyA}, 32'd1);
        check("sb_busyB_r0",  {31'd0, u_if.busyB}, 32'd0);
        set_req(2, 5'd7, 32'h0000_0077);
        u_if.req_valid = 3'b100;
        tick();
        u_if.req_valid = 3'b000;
        check("sb_wb_en",        {31'd0, u_if.wb_en}, 32'd1);
        check("sb_busy_in_wb",   {31'd0, u_if.busyA}, 32'd1);
        tick();
        check("sb_busy_cleared", {31'd0, u_if.busyA}, 32'd0);
        // Re-reserve on the commit edge: set must win
        u_if.rsv_en  = 1'b1;
        u_if.rsv_reg = 5'd7;
        tick();
        u_if.rsv_en = 1'b0;
        u_if.req_valid = 3'b100;
        tick();
        u_if.req_valid = 3'b000;
        u_if.rsv_en    = 1'b1;
        check("sb_wb_en_2", {31'd0, u_if.wb_en}, 32'd1);
        tick();
        u_if.rsv_en = 1'b0;
        check("sb_set_wins", {31'd0, u_if.busyA}, 32'd1);

        // Hold: reserve 10 so the in-flight write after release is observable
        u_if.rsv_en  = 1'b1;
        u_if.rsv_reg = 5'd10;
        tick();
        u_if.rsv_en = 1'b0;
        u_if.chk_regB = 5'd10;
        u_if.hold = 1'b1;
        set_req(0, 5'd10, 32'hCAFE_0001);
        u_if.req_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("hold_ready_%0d", k), {29'd0, u_if.req_ready}, 32'd0);
            tick();
            check($sformatf("hold_wb_en_%0d", k), {31'd0, u_if.wb_en}, 32'd0);
        end
        u_if.hold = 1'b0;
        #1;
        check("release_ready", {29'd0, u_if.req_ready}, 32'd1);
        tick();
        check("release_wb_en",   {31'd0, u_if.wb_en}, 32'd1);
        check("release_wb_reg",  {27'd0, u_if.wb_reg}, 32'd10);
        check("release_wb_data", u_if.wb_data, 32'hCAFE_0001);
        // Hold while the write is driving: it still lands, then wb_en drops
        u_if.hold = 1'b1;
        set_req(0, 5'd12, 32'h0000_0C0C);
        #1;
        check("hold2_ready", {29'd0, u_if.req_ready}, 32'd0);
        tick();
        check("hold2_wb_en",  {31'd0, u_if.wb_en}, 32'd0);
        check("hold2_commit", {31'd0, u_if.busyB}, 32'd0);
        u_if.hold = 1'b0;
        u_if.req_valid = 3'b000;

        // Asynchronous reset mid-cycle with a write in flight and reservations
        set_req(0, 5'd13, 32'h0000_1313);
        u_if.req_valid = 3'b001;
        u_if.rsv_en    = 1'b1;
        u_if.rsv_reg   = 5'd14;
        tick();
        u_if.req_valid = 3'b000;
        u_if.rsv_en    = 1'b0;
        u_if.chk_regA  = 5'd14;
        u_if.chk_regB  = 5'd7;
        #1;
        check("pre_rst_wb_en", {31'd0, u_if.wb_en}, 32'd1);
        check("pre_rst_busyA", {31'd0, u_if.busyA}, 32'd1);
        check("pre_rst_busyB", {31'd0, u_if.busyB}, 32'd1);
        ctrl_reset = 1'b1;
        #1;
        check("arst_wb_en",   {31'd0, u_if.wb_en}, 32'd0);
        check("arst_wb_reg",  {27'd0, u_if.wb_reg}, 32'd0);
        check("arst_wb_data", u_if.wb_data, 32'd0);
        check("arst_busyA",   {31'd0, u_if.busyA}, 32'd0);
        check("arst_busyB",   {31'd0, u_if.busyB}, 32'd0);
        tick();
        ctrl_reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port among NREQ writeback requesters, e.g. ALU, mult/div and load paths.
- Round-robin arbitration; the winner is registered into the write-port drive signals.
- Holds a 32-entry pending-write scoreboard so issue logic can stall on registers whose writeback has not landed.
- Sits between the execute/memory stages and the register file's write port.

Parameters:
- NREQ, 3: number of writeback requesters; legal range 2..8.
- PTR_W, 3: width of the round-robin pointer; must satisfy 2^PTR_W >= NREQ.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- hold  in  1  when 1: no grants and wb_en forced 0 next edge.
- req_valid  in  NREQ  per-requester writeback request.
- req_reg  in  5*NREQ  destination register; slice i = [5i+4:5i].
- req_data  in  32*NREQ  write data; slice i = [32i+31:32i].
- req_ready  out  NREQ  one-hot grant, combinational; request i is accepted on an edge where req_valid[i] && req_ready[i].
- wb_en  out  1  registered write enable to register file.
- wb_reg  out  5  registered write address.
- wb_data  out  32  registered write data.
- rsv_en  in  1  issue logic reserves a destination register.
- rsv_reg  in  5  register being reserved.
- chk_regA  in  5  source A to check.
- chk_regB  in  5  source B to check.
- busyA  out  1  combinational: pending[chk_regA].
- busyB  out  1  combinational: pending[chk_regB].

Behaviour:
- Reset (async, immediate): wb_en=0, wb_reg=0, wb_data=0, pending[31:0]=0, rr_ptr=0 so requester 0 has top priority.
- A reset mid-operation discards any in-flight writeback and all reservations.
- Arbitration: if hold=0 and any req_valid, grant the first valid index searching rr_ptr, rr_ptr+1, ... modulo NREQ.
- req_ready is the one-hot of that index; all zeros if hold=1 or no request is valid.
- At most one grant per cycle. Losers keep req_valid asserted, and their reg/data must stay stable until granted.
- Pointer update: on an accepted grant to index g, rr_ptr <= (g+1) mod NREQ. With no grant, rr_ptr is unchanged.
- Latency: a request accepted at edge k appears on wb_en/wb_reg/wb_data after edge k; the register file writes at edge k+1.
- Throughput: one write per cycle, with no bubbles under back-to-back requests.
- No grant at an edge: wb_en <= 0. wb_reg and wb_data hold their previous values.
- Register 0: a request with req_reg=0 is granted and consumed normally (ready asserted, pointer advances), but wb_en stays 0. Register 0 is never written.
- Scoreboard set: on an edge where rsv_en=1 and rsv_reg!=0, pending[rsv_reg] <= 1. rsv_reg=0 is ignored.
- Scoreboard clear: on an edge where wb_en=1, pending[wb_reg] <= 0. This is the same edge the register file commits the data.
- Simultaneous set and clear of the same register: set wins, so pending stays 1 for the new producer.
- pending[0] is constantly 0, so busyA/busyB are 0 for register 0.
- busyA/busyB are purely combinational on chk_reg* and the current pending state; there is no bypass of a same-edge clear.
- A writeback to a register that is not pending is legal: it is written and pending stays 0.
- hold=1 with wb_en=1 currently driving: that write still completes at the next edge. The following cycle has wb_en=0.

Test Plan:
- Reset then idle: assert ctrl_reset mid-cycle -> wb_en=0, wb_reg=0, wb_data=0 and busyA=busyB=0 immediately, without waiting for a clock edge.
- Single request: req0 reg=5 data=0xDEADBEEF at edge k -> req_ready=001 before edge k. After k, wb_en=1, wb_reg=5, wb_data=0xDEADBEEF. After k+1, wb_en=0.
- Round-robin fairness: all three requesters continuously valid (regs 1,2,3) -> grant order 0,1,2,0,1,2 and wb_reg sequence 1,2,3,1,2,3 with wb_en held high.
- Register 0 drop: req1 reg=0 alone -> req_ready=010, wb_en stays 0 next cycle, rr_ptr advances so a following req1+req2 grants req2 first.
- Scoreboard: rsv reg 7 -> busyA=1 with chk_regA=7. Writeback to 7 via req2 -> busyA=1 through the wb_en cycle and 0 after the commit edge. A same-edge rsv of 7 during the commit keeps busyA=1.
- Hold: hold=1 with req0 valid for 3 cycles -> req_ready=000, wb_en=0. Release hold -> req0 granted next edge with its data unchanged.
